gf2_karatsuba_seq: RTL and testbench

Sequential, parametrised GF(2)[x] polynomial multiplier that computes the full unreduced product of two W-bit operands using one Karatsuba split. A single shared half-width carry-less multiplier is time-multiplexed over three cycles, one per sub-product. It replaces the fixed-width, three-core combinational multipliers where area matters more than latency, and feeds the field-reduction stage through a valid/ready handshake.

---
 rtl/gf2_pkg.sv | 10 +
 rtl/gf2_clmul_comb.sv | 23 ++
 rtl/gf2_karatsuba_seq.sv | 117 +++++++++++
 tb/tb_gf2_karatsuba_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared state encoding and sizing helper for the sequential GF(2)[x] Karatsuba multiplier.
package gf2_pkg;

    typedef enum logic [2:0] {IDLE, S_LO, S_HI, S_MID, DONE} state_e;

    function automatic int unsigned half_w(input int unsigned w);
        return (w + 1) / 2;
    endfunction

endpackage

// File: rtl/gf2_clmul_comb.sv
// N x N schoolbook carry-less multiplier: XOR of shifted, AND-gated copies of i_b.
module gf2_clmul_comb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-2:0] o_p
);
    localparam int unsigned PW = 2 * N - 1;

    logic [PW-1:0] w_sum [N+1];

    assign w_sum[0] = '0;

    for (genvar i = 0; i < N; i++) begin : g_row
        logic [PW-1:0] w_pp;
        assign w_pp       = (PW'(i_b) << i) & {PW{i_a[i]}};
        assign w_sum[i+1] = w_sum[i] ^ w_pp;
    end

    assign o_p = w_sum[N];

endmodule

// File: rtl/gf2_karatsuba_seq.sv
// Sequential one-level Karatsuba GF(2)[x] multiplier; one shared half-width core is
// reused for the L, P and M sub-products on three consecutive cycles.
module gf2_karatsuba_seq
    import gf2_pkg::*;
#(
    parameter int unsigned W = 283
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] y,
    output logic           busy
);
    localparam int unsigned H  = half_w(W);
    localparam int unsigned PW = 2 * H - 1;
    localparam int unsigned AW = 4 * H - 1;

    state_e        r_state, w_state_next;
    logic [W-1:0]  r_ra, r_rb;
    logic [AW-1:0] r_acc, w_acc_next, w_prod_ext;
    logic [H-1:0]  w_ra_lo, w_ra_hi, w_rb_lo, w_rb_hi, w_core_a, w_core_b;
    logic [PW-1:0] w_prod;
    logic          w_in_hs;
    logic          w_unused_acc;

    // High halves are zero-extended to H bits when W is odd.
    assign w_ra_lo = r_ra[H-1:0];
    assign w_rb_lo = r_rb[H-1:0];
    assign w_ra_hi = H'(r_ra >> H);
    assign w_rb_hi = H'(r_rb >> H);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = S_LO;
            S_LO:    w_state_next = S_HI;
            S_HI:    w_state_next = S_MID;
            S_MID:   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = in_valid ? S_LO : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    assign w_in_hs = in_valid && in_ready;

    always_comb begin
        w_core_a = w_ra_lo ^ w_ra_hi;
        w_core_b = w_rb_lo ^ w_rb_hi;
        case (r_state)
            S_LO: begin
                w_core_a = w_ra_lo;
                w_core_b = w_rb_lo;
            end
            S_HI: begin
                w_core_a = w_ra_hi;
                w_core_b = w_rb_hi;
            end
            default: ;
        endcase
    end

    gf2_clmul_comb #(
        .N (H)
    ) u_core (
        .i_a (w_core_a),
        .i_b (w_core_b),
        .o_p (w_prod)
    );

    assign w_prod_ext = AW'(w_prod);

    always_comb begin
        w_acc_next = r_acc;
        case (r_state)
            S_LO:    w_acc_next = r_acc ^ w_prod_ext ^ (w_prod_ext << H);
            S_HI:    w_acc_next = r_acc ^ (w_prod_ext << H) ^ (w_prod_ext << (2 * H));
            S_MID:   w_acc_next = r_acc ^ (w_prod_ext << H);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_acc <= '0;
        end else if (w_in_hs) begin
            r_ra  <= a;
            r_rb  <= b;
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign y = r_acc[2*W-2:0];

    // Top accumulator bits beyond 2W-1 are always zero for odd W.
    assign w_unused_acc = ^r_acc;

endmodule

// File: tb/tb_gf2_karatsuba_seq.sv
// Scoreboard bench for gf2_karatsuba_seq at W=8, W=7 and W=283.
module tb_gf2_karatsuba_seq;
    localparam int unsigned RW = 576;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_valid8 = 1'b0, out_ready8 = 1'b1, in_ready8, out_valid8, busy8;
    logic [7:0]    a8 = '0, b8 = '0;
    logic [14:0]   y8;
    logic          in_valid7 = 1'b0, out_ready7 = 1'b1, in_ready7, out_valid7, busy7;
    logic [6:0]    a7 = '0, b7 = '0;
    logic [12:0]   y7;
    logic          in_valid283 = 1'b0, out_ready283 = 1'b1, in_ready283, out_valid283, busy283;
    logic [282:0]  a283 = '0, b283 = '0;
    logic [564:0]  y283;

    gf2_karatsuba_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .y(y8), .busy(busy8)
    );
    gf2_karatsuba_seq #(.W(7)) dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid7), .in_ready(in_ready7), .a(a7), .b(b7),
        .out_valid(out_valid7), .out_ready(out_ready7), .y(y7), .busy(busy7)
    );
    gf2_karatsuba_seq #(.W(283)) dut283 (
        .clk(clk), .rst(rst), .in_valid(in_valid283), .in_ready(in_ready283), .a(a283),
        .b(b283), .out_valid(out_valid283), .out_ready(out_ready283), .y(y283), .busy(busy283)
    );

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] clmul(input logic [287:0] x, input logic [287:0] z);
        logic [RW-1:0] r = '0;
        for (int i = 0; i < 288; i++) if (x[i]) r = r ^ (RW'(z) << i);
        return r;
    endfunction

    function automatic logic [282:0] rand283();
        logic [287:0] r;
        for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom();
        return r[282:0];
    endfunction

    logic [RW-1:0] q8[$], q7[$], q283[$];
    int n_out8 = 0, n_out7 = 0, n_out283 = 0;
    int t283[$];

    // Expected products are queued at the input handshake, compared at the output handshake.
    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            q7.delete();
            q283.delete();
        end else begin
            if (in_valid8 && in_ready8) q8.push_back(clmul(288'(a8), 288'(b8)));
            if (in_valid7 && in_ready7) q7.push_back(clmul(288'(a7), 288'(b7)));
            if (in_valid283 && in_ready283) q283.push_back(clmul(288'(a283), 288'(b283)));
            if (out_valid8 && out_ready8) begin
                n_out8++;
                check("sb8_pending", RW'(q8.size() != 0), 1);
                if (q8.size() != 0) check("sb8_y", RW'(y8), q8.pop_front());
            end
            if (out_valid7 && out_ready7) begin
                n_out7++;
                check("sb7_pending", RW'(q7.size() != 0), 1);
                if (q7.size() != 0) check("sb7_y", RW'(y7), q7.pop_front());
            end
            if (out_valid283 && out_ready283) begin
                n_out283++;
                t283.push_back(cyc);
                check("sb283_pending", RW'(q283.size() != 0), 1);
                if (q283.size() != 0) check("sb283_y", RW'(y283), q283.pop_front());
            end
        end
    end

    function automatic logic ovld(input int sel);
        case (sel)
            8:       return out_valid8;
            7:       return out_valid7;
            default: return out_valid283;
        endcase
    endfunction

    task automatic wait_out(input int sel);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ovld(sel) && n < 20);
        check("wait_out_valid", RW'(ovld(sel)), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        logic [RW-1:0] exp_big;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", RW'(in_ready8), 1);
        check("rst_out_valid", RW'(out_valid8), 0);
        check("rst_busy", RW'(busy8), 0);
        check("rst_y", RW'(y8), 0);
        check("rst_y283", RW'(y283), 0);
        check("rst_in_ready7", RW'(in_ready7), 1);

        // Latency and busy: accept at edge k, out_valid after edge k+3.
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h03;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lat_busy", RW'(busy8), 1);
            check("lat_not_valid", RW'(out_valid8), 0);
            @(posedge clk);
        end
        @(negedge clk);
        check("lat_valid", RW'(out_valid8), 1);
        check("lat_busy_done", RW'(busy8), 1);
        check("lat_y", RW'(y8), 15'h0005);

        // Backpressure with a competing input that must not be captured.
        @(posedge clk); #1;
        out_ready8 = 1'b0; in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34;
        wait_out(8);
        n0 = n_out8;
        repeat (5) begin
            check("bp_y", RW'(y8), 15'h5555);
            check("bp_valid", RW'(out_valid8), 1);
            check("bp_in_ready", RW'(in_ready8), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1; in_valid8 = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_one_out", RW'(n_out8 - n0), 1);
        check("bp_idle_valid", RW'(out_valid8), 0);
        check("bp_idle_ready", RW'(in_ready8), 1);

        // Odd width, H=4.
        @(posedge clk); #1;
        in_valid7 = 1'b1; a7 = 7'h7F; b7 = 7'h01;
        @(posedge clk); #1;
        in_valid7 = 1'b0;
        wait_out(7);
        check("w7_y_7f", RW'(y7), 13'h007F);
        check("w7_drop_bits", RW'(dut7.r_acc[14:13]), 0);
        @(posedge clk); #1;
        in_valid7 = 1'b1; a7 = 7'h40; b7 = 7'h40;
        @(posedge clk); #1;
        in_valid7 = 1'b0;
        wait_out(7);
        check("w7_y_1000", RW'(y7), 13'h1000);
        check("w7_drop_bits2", RW'(dut7.r_acc[14:13]), 0);

        // Full width: x^282 squared.
        @(posedge clk); #1;
        in_valid283 = 1'b1;
        a283 = '0; a283[282] = 1'b1;
        b283 = a283;
        @(posedge clk); #1;
        in_valid283 = 1'b0;
        wait_out(283);
        exp_big = '0;
        exp_big[564] = 1'b1;
        check("big_y", RW'(y283), exp_big);

        // Back-to-back random pairs with both handshakes held high.
        @(posedge clk); #1;
        t283.delete();
        n0 = n_out283;
        in_valid283 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a283 = rand283();
            b283 = rand283();
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready283 && n < 20);
            check("b2b_accept", RW'(in_ready283), 1);
            @(posedge clk); #1;
        end
        in_valid283 = 1'b0;
        n = 0;
        while ((n_out283 - n0) < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_count", RW'(n_out283 - n0), 4);
        if (t283.size() >= 4)
            for (int i = 1; i < 4; i++) check("b2b_gap", RW'(t283[i] - t283[i-1]), 4);

        // Reset mid-computation in S_HI.
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_busy", RW'(busy8), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", RW'(in_ready8), 1);
        check("mid_rst_valid", RW'(out_valid8), 0);
        check("mid_rst_busy", RW'(busy8), 0);
        check("mid_rst_y", RW'(y8), 0);
        n0 = n_out8;
        repeat (6) @(negedge clk);
        check("mid_no_out", RW'(n_out8 - n0), 0);
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h05;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        wait_out(8);
        check("post_rst_y", RW'(y8), 15'h000F);

        repeat (3) @(negedge clk);
        check("sb_drain", RW'(q8.size() + q7.size() + q283.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
